// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: colour word types, channel reordering and the
// bit/reset timing constants used by both the pixel feeder and the serializer.
package ws2812_pkg;

    typedef logic [23:0] rgb_t;
    typedef logic [23:0] grb_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SEND  = 2'd3
    } feed_state_e;

    // Line timing in nanoseconds; the reset gap covers both old and new LED revisions.
    localparam int T0H_NS   = 400;
    localparam int T0L_NS   = 850;
    localparam int T1H_NS   = 800;
    localparam int T1L_NS   = 450;
    localparam int RESET_NS = 300_000;

    function automatic grb_t rgb_to_grb(input rgb_t c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Simple dual-port pixel store: one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the old colour.
module ws2812_pixel_ram
    import ws2812_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  rgb_t              wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output rgb_t              rd_data_o
);

    rgb_t mem_q [0:(2**ADDR_W)-1];
    rgb_t rd_data_q;

    // Write port and registered read port share one edge, giving read-first order.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ws2812_pixel_feeder.sv
// Streams every stored pixel, brightness-scaled and in GRB wire order, to the
// WS2812 serializer once per refresh period or on an explicit frame request.
module ws2812_pixel_feeder
    import ws2812_pkg::*;
#(
    parameter int LED_NUM        = 8,
    parameter int ADDR_W         = 8,
    parameter int CLK_FRE        = 27_000_000,
    parameter int REFRESH_CYCLES = CLK_FRE / 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_rgb,
    input  logic [7:0]        brightness,
    input  logic              frame_req,
    output logic              px_valid,
    output logic [23:0]       px_data,
    output logic              px_last,
    input  logic              px_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LED_NUM - 1);
    localparam logic [ADDR_W:0]   LED_NUM_W = (ADDR_W + 1)'(LED_NUM);

    feed_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        bri_q, bri_d;
    logic              pend_q, pend_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    grb_t              data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              wr_ok_s;
    logic              tick_s;
    logic              trig_s;
    rgb_t              ram_rgb_s;
    logic [15:0]       bri_mul_s;
    logic [15:0]       prod_r_s, prod_g_s, prod_b_s;
    grb_t              scaled_grb_s;

    assign wr_ok_s = wr_en && ({1'b0, wr_addr} < LED_NUM_W);

    ws2812_pixel_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (wr_ok_s),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_rgb),
        .rd_addr_i (idx_q),
        .rd_data_o (ram_rgb_s)
    );

    // Per-channel brightness scale (c * (bri+1)) >> 8; the product never exceeds 16 bits.
    always_comb begin
        bri_mul_s    = {8'd0, bri_q} + 16'd1;
        prod_r_s     = {8'd0, ram_rgb_s[23:16]} * bri_mul_s;
        prod_g_s     = {8'd0, ram_rgb_s[15:8]} * bri_mul_s;
        prod_b_s     = {8'd0, ram_rgb_s[7:0]} * bri_mul_s;
        scaled_grb_s = rgb_to_grb({prod_r_s[15:8], prod_g_s[15:8], prod_b_s[15:8]});
    end

    // Refresh counter, frame trigger and the fetch/load/send sequencer next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bri_d   = bri_q;
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        tick_s = (cnt_q == CNT_MAX);
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        trig_s = tick_s || frame_req;

        // Requests arriving mid-frame collapse into a single follow-on frame.
        if (busy_q && trig_s) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig_s || pend_q) begin
                    pend_d  = 1'b0;
                    idx_d   = '0;
                    bri_d   = brightness;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                data_d  = scaled_grb_s;
                valid_d = 1'b1;
                last_d  = (idx_q == LAST_IDX);
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (px_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bri_q   <= 8'd0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= 24'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bri_q   <= bri_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign px_valid   = valid_q;
    assign px_data    = data_q;
    assign px_last    = last_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// Bench for ws2812_pixel_feeder: table of scaling vectors plus hand-written
// multi-cycle sequences, with a queue scoreboard checked on every handshake.
module tb_ws2812_pixel_feeder;

    localparam int LED_NUM = 3;
    localparam int ADDR_W  = 8;
    localparam int REFRESH = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [23:0]       wr_rgb = 24'd0;
    logic [7:0]        brightness = 8'd255;
    logic              frame_req = 1'b0;
    logic              px_valid;
    logic [23:0]       px_data;
    logic              px_last;
    logic              px_ready = 1'b0;
    logic              busy;
    logic              frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [23:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic [23:0] rgb;
        logic [7:0]  bri;
        logic [23:0] grb;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[9];

    always #5 clk = ~clk;

    ws2812_pixel_feeder #(
        .LED_NUM        (LED_NUM),
        .ADDR_W         (ADDR_W),
        .CLK_FRE        (1000),
        .REFRESH_CYCLES (REFRESH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_rgb     (wr_rgb),
        .brightness (brightness),
        .frame_req  (frame_req),
        .px_valid   (px_valid),
        .px_data    (px_data),
        .px_last    (px_last),
        .px_ready   (px_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Cycle index since reset release; equals the DUT refresh counter phase.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sync();
        rst       = 1'b1;
        px_ready  = 1'b0;
        frame_req = 1'b0;
        wr_en     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wr_pix(input logic [ADDR_W-1:0] a, input logic [23:0] c);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_rgb  = c;
        sync();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        sync();
        frame_req = 1'b0;
    endtask

    task automatic push_px(input logic [23:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] p2);
        push_px(p0, 1'b0);
        push_px(p1, 1'b0);
        push_px(p2, 1'b1);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!px_valid && n < 40);
        chk(nm, {31'd0, px_valid}, 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 60);
        chk(nm, {31'd0, frame_done}, 32'd1);
    endtask

    task automatic load_rgb3();
        wr_pix(8'd0, 24'hFF0000);
        wr_pix(8'd1, 24'h00FF00);
        wr_pix(8'd2, 24'h0000FF);
    endtask

    // Scoreboard: every handshake pops one expected word; frame_done must follow the last one.
    initial begin
        exp_t e;
        logic fd_exp;
        fd_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (fd_exp || frame_done) chk("frame_done_timing", {31'd0, frame_done}, {31'd0, fd_exp});
                fd_exp = 1'b0;
                if (px_valid && px_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_handshake", px_data, 32'hDEAD);
                    end else begin
                        e = sb.pop_front();
                        chk("px_data", px_data, e.data);
                        chk("px_last", {31'd0, px_last}, {31'd0, e.last});
                    end
                    fd_exp = px_last;
                end
            end else begin
                fd_exp = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before test done");
        $fatal(1);
    end

    initial begin
        int lat;
        int unstable;
        int t1;
        int t2;

        tbl[0] = '{24'hFF0000, 8'd255, 24'h00FF00};
        tbl[1] = '{24'h00FF00, 8'd255, 24'hFF0000};
        tbl[2] = '{24'h0000FF, 8'd255, 24'h0000FF};
        tbl[3] = '{24'h808080, 8'd127, 24'h404040};
        tbl[4] = '{24'h808080, 8'd0,   24'h000000};
        tbl[5] = '{24'hFFFFFF, 8'd0,   24'h000000};
        tbl[6] = '{24'hFFFFFF, 8'd127, 24'h7F7F7F};
        tbl[7] = '{24'h123456, 8'd200, 24'h280E43};
        tbl[8] = '{24'hFF8001, 8'd1,   24'h010100};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_px_valid", {31'd0, px_valid}, 32'd0);
        chk("rst_px_last", {31'd0, px_last}, 32'd0);
        chk("rst_px_data", px_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // LED order, GRB reorder, first-pixel latency
        sync();
        load_rgb3();
        brightness = 8'd255;
        px_ready   = 1'b1;
        push_frame(24'h00FF00, 24'hFF0000, 24'h0000FF);
        pulse_req();
        lat = 1;
        forever begin
            @(negedge clk);
            if (px_valid || lat >= 10) break;
            sync();
            lat++;
        end
        chk("first_valid_latency", lat, 32'd3);
        wait_done("order_done");
        chk("order_sb_empty", sb.size(), 32'd0);

        // Scaling table
        for (int i = 0; i < 9; i++) begin
            do_reset();
            wr_pix(8'd0, tbl[i].rgb);
            wr_pix(8'd1, tbl[i].rgb);
            wr_pix(8'd2, tbl[i].rgb);
            brightness = tbl[i].bri;
            px_ready   = 1'b1;
            push_frame(tbl[i].grb, tbl[i].grb, tbl[i].grb);
            pulse_req();
            wait_done("tbl_done");
            chk("tbl_sb_empty", sb.size(), 32'd0);
        end

        // Backpressure, mid-frame writes, single transfer on one ready cycle
        do_reset();
        load_rgb3();
        brightness = 8'd255;
        pulse_req();
        wait_valid("bp_valid");
        chk("bp_first", px_data, 32'h00FF00);
        sync();
        wr_pix(8'd0, 24'h00FF00);
        wr_pix(8'd2, 24'hFFFFFF);
        unstable = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (px_valid !== 1'b1 || px_data !== 24'h00FF00 || px_last !== 1'b0) unstable++;
        end
        chk("bp_stable", unstable, 32'd0);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        push_px(24'h00FF00, 1'b0);
        sync();
        px_ready = 1'b1;
        sync();
        px_ready = 1'b0;
        wait_valid("bp_next_valid");
        chk("bp_one_step", px_data, 32'hFF0000);
        repeat (5) @(negedge clk);
        push_px(24'hFF0000, 1'b0);
        push_px(24'hFFFFFF, 1'b1);
        push_frame(24'hFF0000, 24'hFF0000, 24'hFFFFFF);
        sync();
        px_ready = 1'b1;
        wait_done("bp_done1");
        wait_done("bp_done2");
        chk("bp_sb_empty", sb.size(), 32'd0);

        // Pending saturation: two requests and a tick while busy give one extra frame
        do_reset();
        load_rgb3();
        brightness = 8'd255;
        pulse_req();
        wait_valid("pend_valid");
        sync();
        pulse_req();
        sync();
        pulse_req();
        for (int k = 0; k < 60 && cyc < 40; k++) sync();
        push_frame(24'h00FF00, 24'hFF0000, 24'h0000FF);
        push_frame(24'h00FF00, 24'hFF0000, 24'h0000FF);
        px_ready = 1'b1;
        wait_done("pend_done1");
        wait_done("pend_done2");
        @(negedge clk);
        chk("pend_no_extra", {31'd0, busy}, 32'd0);
        push_frame(24'h00FF00, 24'hFF0000, 24'h0000FF);
        push_frame(24'h00FF00, 24'hFF0000, 24'h0000FF);
        wait_done("tick_done1");
        t1 = cyc;
        wait_done("tick_done2");
        t2 = cyc;
        chk("tick_period", t2 - t1, REFRESH);
        chk("tick_sb_empty", sb.size(), 32'd0);

        // Brightness change mid-frame affects only the next frame
        do_reset();
        load_rgb3();
        brightness = 8'd255;
        pulse_req();
        wait_valid("bri_valid");
        sync();
        brightness = 8'd0;
        for (int k = 0; k < 60 && cyc < 20; k++) sync();
        push_frame(24'h00FF00, 24'hFF0000, 24'h0000FF);
        push_frame(24'h000000, 24'h000000, 24'h000000);
        px_ready = 1'b1;
        wait_done("bri_done1");
        wait_done("bri_done2");
        chk("bri_sb_empty", sb.size(), 32'd0);

        // Reset during the second pixel's SEND
        do_reset();
        load_rgb3();
        brightness = 8'd255;
        pulse_req();
        wait_valid("rmf_valid0");
        push_px(24'h00FF00, 1'b0);
        sync();
        px_ready = 1'b1;
        sync();
        px_ready = 1'b0;
        wait_valid("rmf_valid1");
        chk("rmf_second", px_data, 32'hFF0000);
        sync();
        pulse_req();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("rmf_px_valid", {31'd0, px_valid}, 32'd0);
        chk("rmf_px_data", px_data, 32'd0);
        chk("rmf_busy", {31'd0, busy}, 32'd0);
        unstable = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy || px_valid || frame_done) unstable++;
        end
        chk("rmf_quiet", unstable, 32'd0);
        chk("rmf_sb_empty", sb.size(), 32'd0);
        sync();
        push_frame(24'h00FF00, 24'hFF0000, 24'h0000FF);
        px_ready = 1'b1;
        pulse_req();
        wait_done("rmf_replay_done");
        chk("rmf_replay_sb_empty", sb.size(), 32'd0);
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ws2812_pixel_feeder.md
Name: ws2812_pixel_feeder

Overview:
- Upstream stage of the WS2812 bit serializer.
- Holds one 24-bit RGB colour per LED in an internal pixel RAM that a host writes.
- Once per refresh period (or on request), streams every pixel in LED order as a brightness-scaled GRB word over a valid/ready handshake.
- The serializer consumes one word per LED and emits the reset gap after px_last.

Parameters:
- LED_NUM, 8, number of LEDs in the chain (1..256).
- ADDR_W, 8, pixel address width; requires 2**ADDR_W >= LED_NUM.
- CLK_FRE, 27_000_000, clock frequency in Hz.
- REFRESH_CYCLES, CLK_FRE/50, clock cycles between automatic frame starts (50 Hz).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  host pixel write strobe.
- wr_addr  in  ADDR_W  LED index to write; writes with wr_addr >= LED_NUM are ignored.
- wr_rgb  in  24  colour to write, packed as {R[23:16], G[15:8], B[7:0]}.
- brightness  in  8  global brightness; 255 means full scale.
- frame_req  in  1  single-cycle pulse requesting an immediate frame.
- px_valid  out  1  px_data holds a valid pixel.
- px_data  out  24  scaled pixel in wire order, {G, R, B}, MSB sent first.
- px_last  out  1  set together with px_valid on the last LED (index LED_NUM-1).
- px_ready  in  1  serializer accepts px_data this cycle.
- busy  out  1  high from frame start until the last pixel is accepted.
- frame_done  out  1  one-cycle pulse the cycle after the last handshake.

Behaviour:

Reset values:
- px_valid=0, px_last=0, px_data=0, busy=0, frame_done=0.
- Refresh counter=0, pending flag=0, FSM in IDLE.
- Pixel RAM is not cleared by rst. It powers up all-zero.

Handshake:
- Transfer occurs when px_valid && px_ready.
- While px_valid=1 and px_ready=0, px_data and px_last hold stable.
- px_valid never drops without a transfer, except on rst.

Refresh counter:
- Free-running 0..REFRESH_CYCLES-1.
- Wrapping to 0 generates a tick.
- A tick or frame_req while busy sets the pending flag. It saturates at one, so extra requests are dropped.

FSM states:
- IDLE: busy=0.
  - On tick, frame_req or pending: clear pending, set idx=0, latch brightness into bri_q, go to FETCH.
  - Tick and frame_req in the same cycle start a single frame.
- FETCH: drive RAM read address idx; busy=1; go to LOAD.
- LOAD: RAM data is valid this cycle (1-cycle synchronous read).
  - Register scaled GRB into px_data; set px_valid=1 and px_last=(idx==LED_NUM-1).
  - Go to SEND.
- SEND: wait for px_ready.
  - On handshake with px_last=0: px_valid=0, idx+1, go to FETCH.
  - On handshake with px_last=1: px_valid=0, pulse frame_done next cycle, go to IDLE.

Throughput:
- 3 cycles per pixel when px_ready is held high. This is negligible against about 30 us per LED on the wire.
- Latency from frame trigger to the first px_valid is 3 cycles: trigger edge, FETCH, LOAD.

Scaling:
- Each channel: out = (c * (bri_q + 1)) >> 8, using a 16-bit product.
- bri_q=255 gives identity; bri_q=0 gives c>>8 = 0.
- Truncate, no rounding.

Timing of inputs:
- brightness is sampled only at frame start, so a mid-frame change takes effect next frame.
- A RAM write in the same cycle as a read of the same address returns the old data (read-first).
- Writes to LEDs not yet fetched appear in the current frame. Writes to LEDs already fetched appear next frame.

Reset mid-frame:
- Abort immediately at the next edge: px_valid=0, no frame_done, pending cleared.
- The downstream serializer shares rst.

Decomposition:
- Shared package ws2812_pkg: RGB/GRB 24-bit typedefs, a function to reorder RGB to GRB, and the WS2812 timing constants (T0H/T0L/T1H/T1L/reset gap) shared with the serializer.
- Natural sub-module ws2812_pixel_ram: simple dual-port, 1 write / 1 read, synchronous read-first, depth 2**ADDR_W x 24.
- Brightness scaling stays inline.

Test Plan:
- Write LED0=FF0000, LED1=00FF00, LED2=0000FF (LED_NUM=3); brightness=255; pulse frame_req; px_ready=1 -> px_data FF0000? no: expect 00FF00, FF0000, 0000FF in that order; px_last only on the third; frame_done one cycle after the third handshake; first px_valid 3 cycles after frame_req.
- brightness=127, LED0=808080 -> px_data=404040. brightness=0 -> 000000.
- Backpressure: hold px_ready=0 for 100 cycles after px_valid rises -> px_data stable, no advance; raise px_ready -> exactly one transfer.
- frame_req twice while busy, plus one refresh tick -> exactly one extra frame after the current one; REFRESH_CYCLES=20 in the bench gives a frame start every 20 cycles when idle.
- Change brightness 255->0 mid-frame -> current frame is unscaled, next frame is all zeros.
- Assert rst during the second pixel's SEND -> px_valid=0 next cycle, no frame_done, RAM contents intact; the next frame replays the original pixels.
